snow64_instr_decoder: RTL and testbench

SNOW64_INSTR_DECODER -- requirements
Module: snow64_instr_decoder

---
 rtl/snow64_instr_decoder.sv | 131 +++++++++++++
 tb/tb_snow64_instr_decoder.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/snow64_instr_decoder.sv
// snow64_instr_decoder
//
// Registered instruction decoder for the Snow64 fixed-format 32-bit ISA.
// Every group uses the same field map:
//   [31:29] group, [28:25] ra, [24:21] rb, [20:17] rc,
//   [16:13] oper,  [12] op_type, [11:0] simm12
// Decoded fields reach the outputs one clock edge after in_instr when
// in_en=1. When in_en=0 the outputs hold.
//
// Ports:
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   in_en        in   decode-register load enable
//   in_instr     in   raw 32-bit instruction word
//   out_group    out  instruction group (3)
//   out_oper     out  operation within group (4)
//   out_ra_index out  register index a (4)
//   out_rb_index out  register index b (4)
//   out_rc_index out  register index c (4)
//   out_op_type  out  0 = scalar, 1 = vector
//   out_simm     out  sign-extended 12-bit immediate (64)
//   out_nop      out  1 = invalid / non-executable, treat as bubble
//
// Configuration macro: SNOW64_INSTR_DECODER_NOP_ZERO_FIELDS_EN
//   If it is defined, any decode with out_nop=1 forces all other outputs to 0.
//   If it is undefined (the default), the raw field decode is always driven.

module snow64_instr_decoder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_en,
    input  logic [31:0] in_instr,
    output logic [2:0]  out_group,
    output logic [3:0]  out_oper,
    output logic [3:0]  out_ra_index,
    output logic [3:0]  out_rb_index,
    output logic [3:0]  out_rc_index,
    output logic        out_op_type,
    output logic [63:0] out_simm,
    output logic        out_nop
);

    typedef enum logic [2:0] {
        GRP_ALU   = 3'd0,
        GRP_CTRL  = 3'd1,
        GRP_LOAD  = 3'd2,
        GRP_STORE = 3'd3
    } group_e;

    logic [2:0]  w_group;
    logic [3:0]  w_oper;
    logic [3:0]  w_ra;
    logic [3:0]  w_rb;
    logic [3:0]  w_rc;
    logic        w_op_type;
    logic [63:0] w_simm;
    logic        w_nop;

    logic [2:0]  r_group;
    logic [3:0]  r_oper;
    logic [3:0]  r_ra;
    logic [3:0]  r_rb;
    logic [3:0]  r_rc;
    logic        r_op_type;
    logic [63:0] r_simm;
    logic        r_nop;

    always_comb begin
        w_group   = in_instr[31:29];
        w_ra      = in_instr[28:25];
        w_rb      = in_instr[24:21];
        w_rc      = in_instr[20:17];
        w_oper    = in_instr[16:13];
        w_op_type = in_instr[12];
        w_simm    = {{52{in_instr[11]}}, in_instr[11:0]};

        // Each group has its own range of legal operations. Groups 4-7 are
        // reserved, so they always decode as a bubble.
        case (group_e'(w_group))
            GRP_ALU:   w_nop = (w_oper > 4'd13);
            GRP_CTRL:  w_nop = (w_oper > 4'd3);
            GRP_LOAD:  w_nop = (w_oper > 4'd10);
            GRP_STORE: w_nop = (w_oper > 4'd10);
            default:   w_nop = 1'b1;
        endcase

`ifdef SNOW64_INSTR_DECODER_NOP_ZERO_FIELDS_EN
        if (w_nop) begin
            w_group   = '0;
            w_ra      = '0;
            w_rb      = '0;
            w_rc      = '0;
            w_oper    = '0;
            w_op_type = 1'b0;
            w_simm    = '0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_group   <= '0;
            r_oper    <= '0;
            r_ra      <= '0;
            r_rb      <= '0;
            r_rc      <= '0;
            r_op_type <= 1'b0;
            r_simm    <= '0;
            r_nop     <= 1'b1;
        end else if (in_en) begin
            r_group   <= w_group;
            r_oper    <= w_oper;
            r_ra      <= w_ra;
            r_rb      <= w_rb;
            r_rc      <= w_rc;
            r_op_type <= w_op_type;
            r_simm    <= w_simm;
            r_nop     <= w_nop;
        end
    end

    assign out_group    = r_group;
    assign out_oper     = r_oper;
    assign out_ra_index = r_ra;
    assign out_rb_index = r_rb;
    assign out_rc_index = r_rc;
    assign out_op_type  = r_op_type;
    assign out_simm     = r_simm;
    assign out_nop      = r_nop;

endmodule

// File: tb/tb_snow64_instr_decoder.sv
module tb_snow64_instr_decoder;

    logic        clk;
    logic        rst_n;
    logic        in_en;
    logic [31:0] in_instr;
    logic [2:0]  out_group;
    logic [3:0]  out_oper;
    logic [3:0]  out_ra_index;
    logic [3:0]  out_rb_index;
    logic [3:0]  out_rc_index;
    logic        out_op_type;
    logic [63:0] out_simm;
    logic        out_nop;

    snow64_instr_decoder dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_en        (in_en),
        .in_instr     (in_instr),
        .out_group    (out_group),
        .out_oper     (out_oper),
        .out_ra_index (out_ra_index),
        .out_rb_index (out_rb_index),
        .out_rc_index (out_rc_index),
        .out_op_type  (out_op_type),
        .out_simm     (out_simm),
        .out_nop      (out_nop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  group;
        logic [3:0]  oper;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [3:0]  rc;
        logic        op_type;
        logic [63:0] simm;
        logic        nop;
    } exp_t;

    typedef struct {
        logic [31:0] instr;
        logic        en;
        exp_t        exp;
    } vec_t;

    int unsigned n_cmp;
    int unsigned n_bad;
    exp_t        sb_q[$];
    exp_t        last_exp;
    exp_t        rst_exp;
    vec_t        vecs[$];

    function automatic exp_t mk(input logic [2:0] g, input logic [3:0] o,
                                input logic [3:0] a, input logic [3:0] b,
                                input logic [3:0] c, input logic t,
                                input logic [63:0] s, input logic n);
        exp_t e;
        e.group = g; e.oper = o; e.ra = a; e.rb = b; e.rc = c;
        e.op_type = t; e.simm = s; e.nop = n;
`ifdef SNOW64_INSTR_DECODER_NOP_ZERO_FIELDS_EN
        if (n) begin
            e.group = '0; e.oper = '0; e.ra = '0; e.rb = '0; e.rc = '0;
            e.op_type = 1'b0; e.simm = '0;
        end
`endif
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input exp_t e);
        chk({tag, ".group"},   64'(out_group),    64'(e.group));
        chk({tag, ".oper"},    64'(out_oper),     64'(e.oper));
        chk({tag, ".ra"},      64'(out_ra_index), 64'(e.ra));
        chk({tag, ".rb"},      64'(out_rb_index), 64'(e.rb));
        chk({tag, ".rc"},      64'(out_rc_index), 64'(e.rc));
        chk({tag, ".op_type"}, 64'(out_op_type),  64'(e.op_type));
        chk({tag, ".simm"},    out_simm,          e.simm);
        chk({tag, ".nop"},     64'(out_nop),      64'(e.nop));
    endtask

    // Drive one vector at the falling edge, push its expected result, then
    // pop and compare just after the following rising edge.
    task automatic apply(input string tag, input logic [31:0] instr, input logic en,
                         input exp_t e);
        exp_t got_exp;
        @(negedge clk);
        in_instr = instr;
        in_en    = en;
        if (en) last_exp = e;
        sb_q.push_back(last_exp);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: scoreboard empty, got 0 entries expected 1", tag);
        end else begin
            got_exp = sb_q.pop_front();
            chk_all(tag, got_exp);
        end
    endtask

    function automatic void add(input logic [31:0] instr, input logic en, input exp_t e);
        vec_t v;
        v.instr = instr; v.en = en; v.exp = e;
        vecs.push_back(v);
    endfunction

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_exp.group = '0; rst_exp.oper = '0; rst_exp.ra = '0; rst_exp.rb = '0;
        rst_exp.rc = '0; rst_exp.op_type = 1'b0; rst_exp.simm = '0; rst_exp.nop = 1'b1;
        last_exp = rst_exp;

        //  instr         en    grp  oper ra   rb   rc   t    simm                    nop
        add(32'h0246A000, 1'b1, mk(3'd0, 4'd5,  4'd1,  4'd2,  4'd3,  1'b0, 64'h0, 1'b0));
        add(32'h20008000, 1'b1, mk(3'd1, 4'd4,  4'd0,  4'd0,  4'd0,  1'b0, 64'h0, 1'b1));
        add(32'h00000FFF, 1'b1, mk(3'd0, 4'd0,  4'd0,  4'd0,  4'd0,  1'b0, 64'hFFFFFFFFFFFFFFFF, 1'b0));
        add(32'h000007FF, 1'b1, mk(3'd0, 4'd0,  4'd0,  4'd0,  4'd0,  1'b0, 64'h00000000000007FF, 1'b0));
        add(32'h80000000, 1'b1, mk(3'd4, 4'd0,  4'd0,  4'd0,  4'd0,  1'b0, 64'h0, 1'b1));
        add(32'h00000000, 1'b1, mk(3'd0, 4'd0,  4'd0,  4'd0,  4'd0,  1'b0, 64'h0, 1'b0));
        add(32'h0001A000, 1'b1, mk(3'd0, 4'd13, 4'd0,  4'd0,  4'd0,  1'b0, 64'h0, 1'b0));
        add(32'h0001C000, 1'b1, mk(3'd0, 4'd14, 4'd0,  4'd0,  4'd0,  1'b0, 64'h0, 1'b1));
        add(32'h20006000, 1'b1, mk(3'd1, 4'd3,  4'd0,  4'd0,  4'd0,  1'b0, 64'h0, 1'b0));
        add(32'h40014000, 1'b1, mk(3'd2, 4'd10, 4'd0,  4'd0,  4'd0,  1'b0, 64'h0, 1'b0));
        add(32'h40016000, 1'b1, mk(3'd2, 4'd11, 4'd0,  4'd0,  4'd0,  1'b0, 64'h0, 1'b1));
        add(32'h60015800, 1'b1, mk(3'd3, 4'd10, 4'd0,  4'd0,  4'd0,  1'b1, 64'hFFFFFFFFFFFFF800, 1'b0));
        add(32'h60016000, 1'b1, mk(3'd3, 4'd11, 4'd0,  4'd0,  4'd0,  1'b0, 64'h0, 1'b1));
        add(32'hA0000000, 1'b1, mk(3'd5, 4'd0,  4'd0,  4'd0,  4'd0,  1'b0, 64'h0, 1'b1));
        add(32'hC0002000, 1'b1, mk(3'd6, 4'd1,  4'd0,  4'd0,  4'd0,  1'b0, 64'h0, 1'b1));
        add(32'hFFFFFFFF, 1'b1, mk(3'd7, 4'd15, 4'd15, 4'd15, 4'd15, 1'b1, 64'hFFFFFFFFFFFFFFFF, 1'b1));
        add(32'h0246A000, 1'b1, mk(3'd0, 4'd5,  4'd1,  4'd2,  4'd3,  1'b0, 64'h0, 1'b0));
        add(32'h80000000, 1'b0, rst_exp); // hold: expected is the prior load
        add(32'h00000FFF, 1'b0, rst_exp);

        in_en    = 1'b0;
        in_instr = '0;
        rst_n    = 1'b0;
        #12;
        chk_all("reset", rst_exp);

        // Reset must win over in_en across a clock edge.
        @(negedge clk);
        in_en    = 1'b1;
        in_instr = 32'h0246A000;
        @(posedge clk);
        #1;
        chk_all("reset_vs_en", rst_exp);

        @(negedge clk);
        in_en = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_all("post_reset_idle", rst_exp);

        for (int i = 0; i < vecs.size(); i++)
            apply($sformatf("vec%0d", i), vecs[i].instr, vecs[i].en, vecs[i].exp);

        // Asynchronous reset between edges, while holding a valid decode.
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("async_reset", rst_exp);
        last_exp = rst_exp;

        @(negedge clk);
        rst_n = 1'b1;
        apply("first_after_reset", 32'h20008000, 1'b1,
              mk(3'd1, 4'd4, 4'd0, 4'd0, 4'd0, 1'b0, 64'h0, 1'b1));
        apply("second_after_reset", 32'h0246A000, 1'b1,
              mk(3'd0, 4'd5, 4'd1, 4'd2, 4'd3, 1'b0, 64'h0, 1'b0));

        if (sb_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d left expected 0", sb_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish by 100000");
        $fatal(1, "timeout");
    end

endmodule
